// File: rtl/full_adder_bist_if.sv
// Adder-under-test bus: the BIST (master) drives operands and reads back
// the adder's sum and carry-out; the adder itself sits on the slave side.
interface full_adder_bist_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (
    output dut_a,
    output dut_b,
    output dut_cin,
    input  dut_sum,
    input  dut_cout
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_cin,
    output dut_sum,
    output dut_cout
  );
endinterface

// File: rtl/full_adder_bist.sv
// Built-in self-test for a WIDTH-bit full adder. It walks every
// {a,b,cin} vector in ascending order and holds each one for SETTLE cycles.
// It compares the adder's result against an internal golden sum and reports
// pass/fail, a saturating error count and the index of the first failing vector.
module full_adder_bist #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  full_adder_bist_if.master    adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int IDX_W = 2 * WIDTH + 1;
  // Hold counter needs at least one bit even when SETTLE is 1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;

  logic [WIDTH:0]   golden;
  logic [WIDTH:0]   observed;
  logic             mismatch;
  logic             err_sat;

  // The vector index is the operand bus. It is cleared by reset and on
  // completion, so the adder inputs fall back to 0 whenever no run is active.
  assign adder.dut_cin = idx[0];
  assign adder.dut_b   = idx[WIDTH:1];
  assign adder.dut_a   = idx[2*WIDTH:WIDTH+1];

  // Golden result and comparison. Case-inequality makes X/Z on the adder
  // outputs count as a mismatch in simulation.
  always_comb begin
    golden   = {1'b0, idx[2*WIDTH:WIDTH+1]} + {1'b0, idx[WIDTH:1]}
             + {{WIDTH{1'b0}}, idx[0]};
    observed = {adder.dut_cout, adder.dut_sum};
    mismatch = (observed !== golden);
    err_sat  = &err_count;
  end

  // Sequencer: accept start, step through the vectors, sample and score, then finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        RUN: begin
          if (wait_cnt == CNT_LAST) begin
            // Last edge of the hold period: score this vector and move on.
            wait_cnt <= '0;
            if (mismatch) begin
              if (!err_sat) begin
                err_count <= err_count + 1'b1;
              end
              if (err_count == '0) begin
                fail_vec <= idx;
              end
            end
            if (&idx) begin
              state <= DONE;
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
